// File: rtl/mem_sequencer.sv
// ============================================================================
// Module   : mem_sequencer
// Purpose  : Word-access sequencer with fixed wait states, feeding the MDR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_sequencer #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] MAR_addr,
  input  logic [31:0]       MDR_data,
  output logic [31:0]       Mdatain,
  output logic              mem_done,
  output logic              busy,
  output logic              err
);

  localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      c_WAIT  = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_data;
  logic                r_op_wr;
  logic [31:0]         r_mdatain;
  logic                r_err;
  logic [31:0]         r_mem [DEPTH];

  logic                w_start;
  logic                w_conflict;
  logic                w_access;
  logic                w_in_range;
  logic [c_IDX_W-1:0]  w_idx;
  logic [31:0]         w_ram_q;

  assign w_in_range = ({1'b0, r_addr} < c_DEPTH);
  assign w_idx      = r_addr[c_IDX_W-1:0];
  // Out-of-range indices are masked below, so any value read here is don't-care
  assign w_ram_q    = r_mem[w_idx];

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_conflict = 1'b0;
    w_access   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Read && Write) begin
          w_conflict = 1'b1;
        end else if (Read || Write) begin
          w_start = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_data    <= 32'd0;
      r_op_wr   <= 1'b0;
      r_mdatain <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_conflict | (w_access & ~w_in_range);
      if (w_start) begin
        r_addr  <= MAR_addr;
        r_op_wr <= Write;
        r_cnt   <= c_WAIT;
        if (Write) begin
          r_data <= MDR_data;
        end
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access && !r_op_wr) begin
        r_mdatain <= w_in_range ? w_ram_q : 32'd0;
      end
    end
  end

  // RAM has no reset; an asynchronous clear forces IDLE, so no write can fire
  always_ff @(posedge clock) begin
    if (w_access && r_op_wr && w_in_range) begin
      r_mem[w_idx] <= r_data;
    end
  end

  assign Mdatain  = r_mdatain;
  assign err      = r_err;
  assign mem_done = (r_state == S_DONE);
  assign busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire
